// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the execute-stage branch logic.
//   - funct3 encodings of the RV32I conditional branches
//   - bht_ctr_t 2-bit saturating counter type and its four states
//   - br_state_t redirect FSM states
//   - helpers: branch outcome decode and saturating counter step
package core_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } br_state_t;

    // The comparator already folds signedness and the >= inversion into Lt,
    // so every relational branch simply follows Lt.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       eq,
                                          input logic       lt);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = lt;
            F3_BLTU: taken = lt;
            F3_BGEU: taken = lt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // One step of a 2-bit saturating counter.
    function automatic bht_ctr_t ctr_step(input bht_ctr_t ctr,
                                          input logic     taken);
        bht_ctr_t nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolver_bht.sv
// bht: branch history table of 2-bit saturating counters.
//   clk, rst_n  : clock, asynchronous active-low reset (all entries -> WNT)
//   rd_idx      : combinational read index
//   rd_taken    : prediction (bit 1 of the indexed counter), pre-update value
//   upd_en      : apply one saturating update at the next rising edge
//   upd_idx     : entry to update
//   upd_taken   : increment when 1, decrement when 0
module bht
    import core_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    bht_ctr_t ctr_r [DEPTH];

    // Counter array: reset to weakly not-taken, saturating update on resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= WNT;
            end
        end else if (upd_en) begin
            ctr_r[upd_idx] <= ctr_step(ctr_r[upd_idx], upd_taken);
        end
    end

    // Read sees the stored value, so a same-cycle update is not bypassed.
    assign rd_taken = ctr_r[rd_idx][1];

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage branch resolution and direction prediction.
//   if_pc / if_pred_taken        : fetch-side prediction lookup (combinational)
//   ex_* , Eq, Lt                : EX instruction and comparator flags
//   Comp_Sel, BrUn               : comparator selects derived from ex_funct3
//   redirect_valid/pc, flush     : registered one-cycle redirect on mispredict/jump
//   branch_cnt, mispred_cnt      : resolved-branch and branch-mispredict counters
module branch_resolver
    import core_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic [2:0]  Comp_Sel,
    output logic        BrUn,
    input  logic        Eq,
    input  logic        Lt,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    br_state_t   state_r;
    logic        resolve_s;
    logic        taken_s;
    logic        br_res_s;
    logic        jump_res_s;
    logic        mispred_s;
    logic [31:0] next_pc_s;
    logic        unused_ok_s;

    assign Comp_Sel = ex_funct3;
    assign BrUn     = ex_funct3[1];

    // Only the index bits of the fetch PC feed the table.
    assign unused_ok_s = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Resolution decode; a jump takes precedence if both flags were ever set.
    always_comb begin
        resolve_s  = ex_valid && !ex_stall && (state_r == IDLE);
        taken_s    = branch_taken(ex_funct3, Eq, Lt);
        jump_res_s = resolve_s && ex_is_jump;
        br_res_s   = resolve_s && ex_is_branch && !ex_is_jump;
        mispred_s  = br_res_s && (taken_s != ex_pred_taken);
        if (jump_res_s) begin
            next_pc_s = ex_target;
        end else if (taken_s) begin
            next_pc_s = ex_target;
        end else begin
            next_pc_s = ex_pc + 32'd4;
        end
    end

    bht #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_taken  (if_pred_taken),
        .upd_en    (br_res_s),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (taken_s)
    );

    // Redirect FSM: a single REDIRECT cycle, never chained back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mispred_s || jump_res_s) begin
                        state_r        <= REDIRECT;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        redirect_pc    <= next_pc_s;
                    end else begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b0;
                    end
                end
                REDIRECT: begin
                    state_r        <= IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                end
            endcase
        end
    end

    // Event counters, wrapping modulo 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else begin
            if (br_res_s) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispred_s) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule
